// File: rtl/mtncl_stage_seq.sv
// Clocked sequencer for one MTNCL datapath: dual-rail encode, DATA/NULL wavefront supervision, result return.
// Optional rail-fault detection is enabled by defining MTNCL_SEQ_RAILCHK_EN.
module mtncl_stage_seq #(
    parameter int WIDTH       = 8,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2,
    parameter int RST_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [WIDTH-1:0] dp_t,
    output logic [WIDTH-1:0] dp_f,
    output logic             dp_sleep,
    output logic             dp_rst,
    input  logic [WIDTH-1:0] res_t,
    input  logic [WIDTH-1:0] res_f
);

    localparam logic [2:0] ST_RST_DP = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_NULL   = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             in_ready_d, out_valid_d, out_err_d, dp_sleep_d, dp_rst_d;
    logic [WIDTH-1:0] out_data_d, dp_t_d, dp_f_d;

    // Completion detection on the asynchronous result rails
    logic raw_complete;
    logic raw_null;
    logic [SYNC_STAGES-1:0] cmp_sync_q;
    logic [SYNC_STAGES-1:0] nul_sync_q;
    logic sync_complete;
    logic sync_null;
    logic sync_illegal;
    logic sync_ok;

    assign raw_complete  = &(res_t | res_f);
    assign raw_null      = ~|(res_t | res_f);
    assign sync_complete = cmp_sync_q[SYNC_STAGES-1];
    assign sync_null     = nul_sync_q[SYNC_STAGES-1];

    // Flags are stale until SYNC_STAGES cycles after the wavefront was launched
    assign sync_ok = (32'(tmo_cnt_q) >= 32'(SYNC_STAGES));

`ifdef MTNCL_SEQ_RAILCHK_EN
    logic raw_illegal;
    logic [SYNC_STAGES-1:0] ill_sync_q;

    assign raw_illegal  = |(res_t & res_f);
    assign sync_illegal = ill_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ill_sync_q <= '0;
        end else begin
            ill_sync_q <= {ill_sync_q[SYNC_STAGES-2:0], raw_illegal};
        end
    end
`else
    assign sync_illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_sync_q <= '0;
            nul_sync_q <= '0;
        end else begin
            cmp_sync_q <= {cmp_sync_q[SYNC_STAGES-2:0], raw_complete};
            nul_sync_q <= {nul_sync_q[SYNC_STAGES-2:0], raw_null};
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        rst_cnt_d = rst_cnt_q;
        op_d      = op_q;
        result_d  = result_q;
        case (state_q)
            ST_RST_DP: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d    = in_data;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sync_illegal) begin
                    state_d = ST_ERR;
                end else if (sync_ok && sync_complete) begin
                    // Rails are monotonic and held by the datapath, so res_t is stable here
                    result_d = res_t;
                    state_d  = ST_NULL;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_NULL: begin
                if (sync_illegal) begin
                    state_d = ST_ERR;
                end else if (sync_ok && sync_null) begin
                    state_d = ST_OUT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (out_ready) begin
                    state_d = ST_RST_DP;
                end
            end
            default: begin
                state_d = ST_RST_DP;
            end
        endcase
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
            rst_cnt_d = '0;
        end
    end

    // Outputs are registered copies decoded from the next state
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_OUT) || (state_d == ST_ERR);
        out_err_d   = (state_d == ST_ERR);
        out_data_d  = (state_d == ST_OUT) ? result_d : '0;
        dp_sleep_d  = (state_d != ST_DATA);
        dp_rst_d    = (state_d == ST_RST_DP);
        dp_t_d      = (state_d == ST_DATA) ? op_d : '0;
        dp_f_d      = (state_d == ST_DATA) ? ~op_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RST_DP;
            tmo_cnt_q <= '0;
            rst_cnt_q <= '0;
            op_q      <= '0;
            result_q  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_data  <= '0;
            dp_t      <= '0;
            dp_f      <= '0;
            dp_sleep  <= 1'b1;
            dp_rst    <= 1'b1;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            rst_cnt_q <= rst_cnt_d;
            op_q      <= op_d;
            result_q  <= result_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_err   <= out_err_d;
            out_data  <= out_data_d;
            dp_t      <= dp_t_d;
            dp_f      <= dp_f_d;
            dp_sleep  <= dp_sleep_d;
            dp_rst    <= dp_rst_d;
        end
    end

endmodule

// File: tb/tb_mtncl_stage_seq.sv
// Bench for mtncl_stage_seq with a one-cycle buffer model of the MTNCL datapath.
// Handshake: a transfer happens on a clk edge where valid && ready are both 1.
module tb_mtncl_stage_seq;
  localparam int W   = 8;
  localparam int TMO = 64;
  localparam int SS  = 2;
  localparam int RC  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_err;
  logic [W-1:0] dp_t, dp_f;
  logic         dp_sleep, dp_rst;
  logic [W-1:0] res_t = '0;
  logic [W-1:0] res_f = '0;

  // datapath model knobs
  logic [W-1:0] drop_mask = '0;
  logic         hold_mode = 1'b0;
  logic         force_bit2 = 1'b0;

  logic [W:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  mtncl_stage_seq #(.WIDTH(W), .TIMEOUT(TMO), .SYNC_STAGES(SS), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .dp_t(dp_t), .dp_f(dp_f), .dp_sleep(dp_sleep), .dp_rst(dp_rst),
    .res_t(res_t), .res_f(res_f)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dp_rst) begin
      res_t <= '0;
      res_f <= '0;
    end else if (!(hold_mode && dp_sleep)) begin
      res_t <= (dp_t & ~drop_mask) | ((force_bit2 && !dp_sleep) ? W'(4) : '0);
      res_f <= (dp_f & ~drop_mask) | ((force_bit2 && !dp_sleep) ? W'(4) : '0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver: offer one operand, push what the bench expects back
  task automatic send(input logic [W-1:0] d, input logic [W:0] exp);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold, output int lat);
    logic [W:0] e;
    logic [W-1:0] held;
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
    if (hold > 0) begin
      held = out_data;
      in_valid = 1'b1;
      in_data  = 8'h55;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(held));
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    check("sb_size", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("result", 32'({out_err, out_data}), 32'(e));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic count_rst(input string tag);
    int c = 0;
    while (dp_rst && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, 32'(c), 32'(RC));
  endtask

  initial begin
    int lat;
    logic [W-1:0] d;
    logic [W:0] rail_exp;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_dp_rails", 32'({dp_t, dp_f}), 32'd0);
    check("rst_dp_sleep", 32'(dp_sleep), 32'd1);
    check("rst_dp_rst", 32'(dp_rst), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    count_rst("rst_len");
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_sleep", 32'(dp_sleep), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // nominal
    send(8'hA5, {1'b0, 8'hA5});
    check("data_dp_t", 32'(dp_t), 32'h0A5);
    check("data_dp_f", 32'(dp_f), 32'h05A);
    check("data_sleep", 32'(dp_sleep), 32'd0);
    check("data_in_ready", 32'(in_ready), 32'd0);
    wait_result(0, lat);
    check("nominal_latency_ok", 32'(lat >= 2 * SS + 4), 32'd1);
    check("back_to_idle", 32'(in_ready), 32'd1);

    // back-pressure
    send(8'h3C, {1'b0, 8'h3C});
    wait_result(10, lat);
    send(8'hC3, {1'b0, 8'hC3});
    wait_result(0, lat);

    // random operands
    for (int i = 0; i < 4; i++) begin
      d = W'($urandom_range(0, 255));
      send(d, {1'b0, d});
      wait_result($urandom_range(0, 3), lat);
    end

    // DATA timeout: bit 7 never completes
    drop_mask = 8'h80;
    send(8'hFF, {1'b1, 8'h00});
    wait_result(0, lat);
    check("data_tmo_latency", 32'(lat), 32'(TMO));
    check("err_dp_rst", 32'(dp_rst), 32'd1);
    count_rst("err_rst_len");
    drop_mask = '0;

    // NULL timeout: rails held after sleep
    hold_mode = 1'b1;
    send(8'h0F, {1'b1, 8'h00});
    wait_result(0, lat);
    check("null_tmo_latency", 32'(lat), 32'(SS + 2 + TMO));
    count_rst("null_err_rst_len");
    hold_mode = 1'b0;

    // reset during DATA
    send(8'h11, {1'b0, 8'h11});
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_sleep", 32'(dp_sleep), 32'd1);
    check("midrst_dp_rst", 32'(dp_rst), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_rst("midrst_rst_len");
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_result", 32'(out_valid), 32'd0);

    // illegal dual-rail code on bit 2
`ifdef MTNCL_SEQ_RAILCHK_EN
    rail_exp = {1'b1, 8'h00};
`else
    rail_exp = {1'b0, 8'h5C};
`endif
    force_bit2 = 1'b1;
    send(8'h5C, rail_exp);
    wait_result(0, lat);
    force_bit2 = 1'b0;

    send(8'h96, {1'b0, 8'h96});
    wait_result(0, lat);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
